scr1_timer_arb: RTL and testbench

//  Round-robin arbiter sharing the single memory-mapped timer register port among NREQ requesters
//  (core dmem, debug/system-bus master, ...). Sits directly in front of the timer's dmem port.

---
 rtl/scr1_timer_arb_pkg.sv | 30 +++
 rtl/scr1_rr_picker.sv | 30 +++
 rtl/scr1_timer_arb.sv | 118 +++++++++++
 tb/tb_scr1_timer_arb.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_timer_arb_pkg.sv
// Shared types for the timer-port arbiter: memory interface enums, FSM states and bus widths.
package scr1_timer_arb_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  // Same encodings as the core memory interface, so fields pass straight through.
  typedef enum logic {
    MEM_CMD_RD = 1'b0,
    MEM_CMD_WR = 1'b1
  } mem_cmd_e;

  typedef enum logic [1:0] {
    MEM_WIDTH_BYTE  = 2'd0,
    MEM_WIDTH_HWORD = 2'd1,
    MEM_WIDTH_WORD  = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    MEM_RESP_NOTRDY = 2'd0,
    MEM_RESP_RDY_OK = 2'd1,
    MEM_RESP_RDY_ER = 2'd2
  } mem_resp_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } type_scr1_timer_arb_fsm_e;

endpackage

// File: rtl/scr1_rr_picker.sv
// Rotating priority encoder: the first asserted request at or after ptr (mod NREQ) wins.
module scr1_rr_picker #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  always_comb begin : pick
    logic [PW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = PW'((int'(ptr) + i) % NREQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/scr1_timer_arb.sv
// Round-robin arbiter in front of the timer dmem port: one outstanding transaction,
// responses routed to their owner only, and a forced RDY_ER if the timer never answers.
module scr1_timer_arb
  import scr1_timer_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  mem_cmd_e           cmd_i   [NREQ],
  input  width_e             width_i [NREQ],
  input  logic [DMEM_AW-1:0] addr_i  [NREQ],
  input  logic [DMEM_DW-1:0] wdata_i [NREQ],
  output logic [NREQ-1:0]    req_ack_o,
  output logic [DMEM_DW-1:0] rdata_o [NREQ],
  output mem_resp_e          resp_o  [NREQ],
  output logic               tgt_req,
  output mem_cmd_e           tgt_cmd,
  output width_e             tgt_width,
  output logic [DMEM_AW-1:0] tgt_addr,
  output logic [DMEM_DW-1:0] tgt_wdata,
  input  logic               tgt_req_ack,
  input  logic [DMEM_DW-1:0] tgt_rdata,
  input  mem_resp_e          tgt_resp
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  type_scr1_timer_arb_fsm_e state, state_next;
  logic [PW-1:0]   owner, owner_next;
  logic [PW-1:0]   rr_ptr, rr_next;
  logic [CW-1:0]   tout_cnt, tout_next;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win_idx;
  logic            win_any;
  logic            arb_en;
  logic            accept;

  scr1_rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (req_i),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      tout_cnt <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      rr_ptr   <= rr_next;
      tout_cnt <= tout_next;
    end
  end

  // Arbitration is gated by rst_n so the target port stays quiet while reset is held.
  always_comb begin
    state_next = state;
    owner_next = owner;
    rr_next    = rr_ptr;
    tout_next  = tout_cnt;
    arb_en     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      resp_o[i]  = MEM_RESP_NOTRDY;
      rdata_o[i] = '0;
    end

    case (state)
      IDLE: arb_en = rst_n;
      WAIT_RESP: begin
        resp_o[owner]  = tgt_resp;
        rdata_o[owner] = tgt_rdata;
        if (tgt_resp != MEM_RESP_NOTRDY) begin
          arb_en     = rst_n;
          state_next = IDLE;
        end else if (tout_cnt == CW'(TIMEOUT - 1)) begin
          resp_o[owner]  = MEM_RESP_RDY_ER;
          rdata_o[owner] = '0;
          state_next     = IDLE;
        end else begin
          tout_next = tout_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    tgt_req   = arb_en & win_any;
    accept    = tgt_req & tgt_req_ack;
    tgt_cmd   = MEM_CMD_RD;
    tgt_width = MEM_WIDTH_BYTE;
    tgt_addr  = '0;
    tgt_wdata = '0;
    if (tgt_req) begin
      tgt_cmd   = cmd_i[win_idx];
      tgt_width = width_i[win_idx];
      tgt_addr  = addr_i[win_idx];
      tgt_wdata = wdata_i[win_idx];
    end
    req_ack_o = accept ? grant : '0;

    // A new accept overrides the completion path, giving one transaction per cycle.
    if (accept) begin
      owner_next = win_idx;
      rr_next    = (win_idx == PW'(NREQ - 1)) ? '0 : PW'(win_idx + 1'b1);
      tout_next  = '0;
      state_next = WAIT_RESP;
    end
  end

endmodule

// File: tb/tb_scr1_timer_arb.sv
// Self-checking bench for scr1_timer_arb: directed scenarios plus random traffic,
// all compared against a transaction-level reference model.
module tb_scr1_timer_arb;
  import scr1_timer_arb_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;
  localparam int VW      = NREQ + NREQ * 2 + NREQ * DMEM_DW + 1 + 1 + 2 + DMEM_AW + DMEM_DW;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  mem_cmd_e           cmd   [NREQ];
  width_e             width [NREQ];
  logic [DMEM_AW-1:0] addr  [NREQ];
  logic [DMEM_DW-1:0] wdata [NREQ];
  logic [NREQ-1:0]    ack;
  logic [DMEM_DW-1:0] rdata_s [NREQ];
  mem_resp_e          resp_s  [NREQ];
  logic               tgt_req;
  mem_cmd_e           tgt_cmd;
  width_e             tgt_width;
  logic [DMEM_AW-1:0] tgt_addr;
  logic [DMEM_DW-1:0] tgt_wdata;
  logic               t_ack;
  logic [DMEM_DW-1:0] t_rdata;
  mem_resp_e          t_resp;

  int checks = 0;
  int errors = 0;

  // Reference model: is a transaction open, who owns it, when was it accepted, who is first in line.
  bit m_busy, m_accept, m_finish;
  int m_owner, m_prio, m_cyc, m_acc_cyc, m_win;
  logic [NREQ-1:0]    e_ack;
  mem_resp_e          e_resp  [NREQ];
  logic [DMEM_DW-1:0] e_rdata [NREQ];
  logic               e_treq;
  mem_cmd_e           e_tcmd;
  width_e             e_twidth;
  logic [DMEM_AW-1:0] e_taddr, e_twdata;

  scr1_timer_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .cmd_i       (cmd),
    .width_i     (width),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .req_ack_o   (ack),
    .rdata_o     (rdata_s),
    .resp_o      (resp_s),
    .tgt_req     (tgt_req),
    .tgt_cmd     (tgt_cmd),
    .tgt_width   (tgt_width),
    .tgt_addr    (tgt_addr),
    .tgt_wdata   (tgt_wdata),
    .tgt_req_ack (t_ack),
    .tgt_rdata   (t_rdata),
    .tgt_resp    (t_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_eval();
    bit grant_ok;
    e_ack = '0;
    e_treq = 1'b0; e_tcmd = MEM_CMD_RD; e_twidth = MEM_WIDTH_BYTE; e_taddr = '0; e_twdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      e_resp[i] = MEM_RESP_NOTRDY;
      e_rdata[i] = '0;
    end
    m_win = -1; m_accept = 0; m_finish = 0;
    if (!rst_n) return;
    grant_ok = 1;
    if (m_busy) begin
      e_resp[m_owner]  = t_resp;
      e_rdata[m_owner] = t_rdata;
      if (t_resp != MEM_RESP_NOTRDY) m_finish = 1;
      else begin
        grant_ok = 0;
        if (m_cyc - m_acc_cyc == TIMEOUT) begin
          e_resp[m_owner] = MEM_RESP_RDY_ER;
          e_rdata[m_owner] = '0;
          m_finish = 1;
        end
      end
    end
    if (grant_ok)
      for (int i = 0; i < NREQ; i++)
        if (m_win < 0 && req[(m_prio + i) % NREQ]) m_win = (m_prio + i) % NREQ;
    if (m_win >= 0) begin
      e_treq = 1'b1;
      e_tcmd = cmd[m_win]; e_twidth = width[m_win]; e_taddr = addr[m_win]; e_twdata = wdata[m_win];
      m_accept = t_ack;
      if (t_ack) e_ack[m_win] = 1'b1;
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      m_busy = 0; m_prio = 0;
    end else if (m_accept) begin
      m_busy = 1; m_owner = m_win; m_acc_cyc = m_cyc; m_prio = (m_win + 1) % NREQ;
    end else if (m_finish) begin
      m_busy = 0;
    end
    m_cyc++;
  endtask

  function automatic logic [VW-1:0] pack_obs();
    return {ack, resp_s[0], resp_s[1], rdata_s[0], rdata_s[1],
            tgt_req, tgt_cmd, tgt_width, tgt_addr, tgt_wdata};
  endfunction

  function automatic logic [VW-1:0] pack_exp();
    return {e_ack, e_resp[0], e_resp[1], e_rdata[0], e_rdata[1],
            e_treq, e_tcmd, e_twidth, e_taddr, e_twdata};
  endfunction

  task automatic sample(output logic [VW-1:0] obs, output logic [VW-1:0] exp);
    #1;
    model_eval();
    obs = pack_obs();
    exp = pack_exp();
  endtask

  task automatic clear_inputs();
    req = '0; t_ack = 1'b0; t_resp = MEM_RESP_NOTRDY; t_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      cmd[i] = MEM_CMD_RD; width[i] = MEM_WIDTH_WORD; addr[i] = '0; wdata[i] = '0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    m_busy = 0; m_prio = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] obs, exp;
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    req = 2'b11; t_ack = 1'b1; t_resp = MEM_RESP_RDY_OK; t_rdata = 32'hDEAD_BEEF;
    addr[0] = 32'h4; addr[1] = 32'h8;
    for (int i = 0; i < 2; i++) begin
      sample(obs, exp);
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("[TB] FAIL reset_quiet cycle %0d: got %h required 0", i, obs);
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reset_model cycle %0d: got %h required %h", i, obs, exp);
      end
      model_commit();
      @(negedge clk);
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic [VW-1:0] obs, exp;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_inputs();
      if (i == 0) begin
        req = 2'b01; addr[0] = 32'h8; t_ack = 1'b1;
      end else begin
        t_resp = MEM_RESP_RDY_OK; t_rdata = 32'h1234;
      end
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL single_read cycle %0d: got %h required %h", i, obs, exp);
      end
      checks++;
      if (ack !== (i == 0 ? 2'b01 : 2'b00) || resp_s[1] !== MEM_RESP_NOTRDY) begin
        errors++;
        $display("[TB] FAIL single_read_ack cycle %0d: got ack %b resp1 %0d", i, ack, resp_s[1]);
      end
      if (i == 1) begin
        checks++;
        if (resp_s[0] !== MEM_RESP_RDY_OK || rdata_s[0] !== 32'h1234) begin
          errors++;
          $display("[TB] FAIL single_read_resp: got %0d/%h required 1/00001234", resp_s[0], rdata_s[0]);
        end
      end
      model_commit();
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] obs, exp;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      clear_inputs();
      req = (i < 6) ? 2'b11 : 2'b00;
      addr[0] = 32'h100; addr[1] = 32'h200;
      t_ack = 1'b1; t_resp = MEM_RESP_RDY_OK; t_rdata = 32'(i);
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d: got %h required %h", i, obs, exp);
      end
      if (i < 6) begin
        checks++;
        if (ack !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("[TB] FAIL back_to_back_order cycle %0d: got %b", i, ack);
        end
      end
      model_commit();
    end
  endtask

  task automatic test_rr_after_req1();
    logic [VW-1:0] obs, exp;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      cmd[1] = MEM_CMD_WR; addr[1] = 32'h10; wdata[1] = 32'hA5A5; addr[0] = 32'h20;
      t_ack = 1'b1;
      if (i == 0) req = 2'b10;
      if (i == 1) begin req = 2'b11; t_resp = MEM_RESP_RDY_OK; end
      if (i == 2) t_resp = MEM_RESP_RDY_OK;
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL rr_after_req1 cycle %0d: got %h required %h", i, obs, exp);
      end
      if (i == 1) begin
        checks++;
        if (ack !== 2'b01 || resp_s[1] !== MEM_RESP_RDY_OK) begin
          errors++;
          $display("[TB] FAIL rr_after_req1_winner: got ack %b resp1 %0d required 01/1", ack, resp_s[1]);
        end
      end
      model_commit();
    end
  endtask

  task automatic test_timeout();
    logic [VW-1:0] obs, exp;
    apply_reset();
    for (int i = 0; i <= TIMEOUT + 3; i++) begin
      @(negedge clk);
      clear_inputs();
      addr[0] = 32'h30; addr[1] = 32'h34;
      if (i == 0) begin req = 2'b01; t_ack = 1'b1; end
      if (i == TIMEOUT) begin req = 2'b10; t_ack = 1'b1; end
      if (i == TIMEOUT + 1) begin t_resp = MEM_RESP_RDY_OK; t_rdata = 32'h77; end
      if (i == TIMEOUT + 2) begin req = 2'b10; t_ack = 1'b1; end
      if (i == TIMEOUT + 3) begin t_resp = MEM_RESP_RDY_OK; t_rdata = 32'h55; end
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL timeout cycle %0d: got %h required %h", i, obs, exp);
      end
      if (i >= 1 && i <= TIMEOUT + 1) begin
        checks++;
        if (resp_s[0] !== ((i == TIMEOUT) ? MEM_RESP_RDY_ER : MEM_RESP_NOTRDY)
            || (i == TIMEOUT && tgt_req !== 1'b0)) begin
          errors++;
          $display("[TB] FAIL timeout_resp cycle %0d: got resp0 %0d tgt_req %b", i, resp_s[0], tgt_req);
        end
      end
      if (i == TIMEOUT + 3) begin
        checks++;
        if (resp_s[1] !== MEM_RESP_RDY_OK || rdata_s[1] !== 32'h55) begin
          errors++;
          $display("[TB] FAIL timeout_recover: got %0d/%h required 1/00000055", resp_s[1], rdata_s[1]);
        end
      end
      model_commit();
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] obs, exp;
    apply_reset();
    @(negedge clk);
    clear_inputs();
    req = 2'b01; addr[0] = 32'h40; t_ack = 1'b1;
    sample(obs, exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL reset_mid_accept: got %h required %h", obs, exp);
    end
    model_commit();
    @(negedge clk);
    clear_inputs();
    #2;
    rst_n = 1'b0;
    req = 2'b11; t_ack = 1'b1; t_resp = MEM_RESP_RDY_OK; t_rdata = 32'h99;
    sample(obs, exp);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_quiet: got %h required 0", obs);
    end
    model_commit();
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_inputs();
      addr[0] = 32'h44;
      if (i == 0) begin req = 2'b01; t_ack = 1'b1; t_resp = MEM_RESP_RDY_OK; t_rdata = 32'h66; end
      else begin t_resp = MEM_RESP_RDY_OK; t_rdata = 32'h88; end
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reset_mid_after cycle %0d: got %h required %h", i, obs, exp);
      end
      checks++;
      if (resp_s[0] !== ((i == 0) ? MEM_RESP_NOTRDY : MEM_RESP_RDY_OK) || (i == 0 && ack !== 2'b01)) begin
        errors++;
        $display("[TB] FAIL reset_mid_stale cycle %0d: got resp0 %0d ack %b", i, resp_s[0], ack);
      end
      model_commit();
    end
  endtask

  task automatic test_ack_stall();
    logic [VW-1:0] obs, exp;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clear_inputs();
      addr[0] = 32'h50; addr[1] = 32'h54; wdata[1] = 32'h1111;
      case (i)
        0: begin req = 2'b01; t_ack = 1'b1; end
        1: begin req = 2'b10; t_resp = MEM_RESP_RDY_OK; end
        2, 3, 4: req = 2'b10;
        5: req = 2'b11;
        6: begin req = 2'b11; t_ack = 1'b1; end
        default: begin t_resp = MEM_RESP_RDY_OK; t_rdata = 32'hCAFE; end
      endcase
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL ack_stall cycle %0d: got %h required %h", i, obs, exp);
      end
      if (i >= 1 && i <= 5) begin
        checks++;
        if (ack !== 2'b00 || tgt_req !== 1'b1 || tgt_addr !== 32'h54) begin
          errors++;
          $display("[TB] FAIL ack_stall_hold cycle %0d: got ack %b req %b addr %h", i, ack, tgt_req, tgt_addr);
        end
      end
      if (i == 7) begin
        checks++;
        if (resp_s[1] !== MEM_RESP_RDY_OK || rdata_s[1] !== 32'hCAFE) begin
          errors++;
          $display("[TB] FAIL ack_stall_resp: got %0d/%h required 1/0000cafe", resp_s[1], rdata_s[1]);
        end
      end
      model_commit();
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] obs, exp;
    int r;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        cmd[i]   = mem_cmd_e'($urandom_range(0, 1));
        width[i] = width_e'($urandom_range(0, 2));
        addr[i]  = $urandom;
        wdata[i] = $urandom;
      end
      t_ack   = ($urandom_range(0, 3) != 0);
      t_rdata = $urandom;
      r = $urandom_range(0, 7);
      t_resp = (r < 4) ? MEM_RESP_NOTRDY : (r < 7) ? MEM_RESP_RDY_OK : MEM_RESP_RDY_ER;
      if ((c % 100) >= 70 && (c % 100) < 92) t_resp = MEM_RESP_NOTRDY;
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h required %h", c, obs, exp);
      end
      model_commit();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    m_busy = 0; m_prio = 0; m_owner = 0; m_cyc = 0; m_acc_cyc = 0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_rr_after_req1();
    test_timeout();
    test_reset_mid();
    test_ack_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
